// File: rtl/cnn4ic_pkg.sv
// Shared constants and types for the classifier output stage.
//   NUM_CLASSES  : class scores per frame
//   CLASS_IDX_W  : width of a class index
//   SCORE_W      : width of a signed class score
//   argmax_state_t : argmax controller state encoding
package cnn4ic_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int CLASS_IDX_W = 4;
    localparam int SCORE_W     = 16;

    typedef enum logic [1:0] {
        ARGMAX_IDLE    = 2'd0,
        ARGMAX_COLLECT = 2'd1,
        ARGMAX_DONE    = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/argmax_sequencer_if.sv
// Score-in / result-out bus of the argmax sequencer.
//   master : upstream score source + downstream result sink (drives Start,
//            Abort, InData/InValid/InLast and OutReady)
//   slave  : the argmax sequencer itself
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. The sender holds data stable while
// valid is high and ready is low; ready never depends combinationally on valid.
// Argmax_DbgState exposes the controller state for observation only.
interface argmax_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    import cnn4ic_pkg::*;

    logic                Argmax_Start;
    logic                Argmax_Abort;
    logic [DATA_W-1:0]   Argmax_InData;
    logic                Argmax_InValid;
    logic                Argmax_InLast;
    logic                Argmax_InReady;
    logic [IDX_W-1:0]    Argmax_OutDigit;
    logic [DATA_W-1:0]   Argmax_OutScore;
    logic                Argmax_OutValid;
    logic                Argmax_OutReady;
    logic                Argmax_Busy;
    logic                Argmax_Error;
    argmax_state_t       Argmax_DbgState;

    modport master (
        output Argmax_Start, Argmax_Abort, Argmax_InData, Argmax_InValid,
               Argmax_InLast, Argmax_OutReady,
        input  Argmax_InReady, Argmax_OutDigit, Argmax_OutScore,
               Argmax_OutValid, Argmax_Busy, Argmax_Error, Argmax_DbgState
    );

    modport slave (
        input  Argmax_Start, Argmax_Abort, Argmax_InData, Argmax_InValid,
               Argmax_InLast, Argmax_OutReady,
        output Argmax_InReady, Argmax_OutDigit, Argmax_OutScore,
               Argmax_OutValid, Argmax_Busy, Argmax_Error, Argmax_DbgState
    );

endinterface

// File: rtl/argmax_compare_stage.sv
// Running maximum register for the argmax sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : first beat of a frame, take in_data/in_idx unconditionally
//   update     : later beat, take in_data/in_idx only if strictly greater
//   in_data    : signed score of the current beat
//   in_idx     : class index of the current beat
//   max_score  : running maximum score
//   max_idx    : index of the running maximum
module argmax_compare_stage #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              update,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    output logic [DATA_W-1:0] max_score,
    output logic [IDX_W-1:0]  max_idx
);

    logic [DATA_W-1:0] max_q;
    logic [IDX_W-1:0]  idx_q;
    logic              greater;

    // Strict signed compare: an equal score never replaces, so ties keep
    // the lower index.
    assign greater = $signed(in_data) > $signed(max_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
            idx_q <= '0;
        end else if (load || (update && greater)) begin
            max_q <= in_data;
            idx_q <= in_idx;
        end
    end

    assign max_score = max_q;
    assign max_idx   = idx_q;

endmodule

// File: rtl/argmax_sequencer.sv
// Sequential argmax controller: collects one frame of class scores, one per
// accepted beat, and presents the index and value of the largest score.
//   Argmax_Clock   : rising-edge clock
//   Argmax_Reset_n : asynchronous active-low reset
//   bus            : argmax_sequencer_if slave (Start/Abort control, score
//                    input stream, result output stream, Busy, Error, state)
module argmax_sequencer #(
    parameter int NUM_CLASSES = cnn4ic_pkg::NUM_CLASSES,
    parameter int DATA_W      = cnn4ic_pkg::SCORE_W,
    parameter int IDX_W       = cnn4ic_pkg::CLASS_IDX_W
) (
    input  logic                 Argmax_Clock,
    input  logic                 Argmax_Reset_n,
    argmax_sequencer_if.slave    bus
);
    import cnn4ic_pkg::*;

    localparam logic [IDX_W-1:0] LAST_COUNT = IDX_W'(NUM_CLASSES - 1);

    argmax_state_t    state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic at_last_count;
    logic final_beat;
    logic cmp_load;
    logic cmp_update;

    assign in_ready      = (state_q == ARGMAX_COLLECT);
    assign out_valid     = (state_q == ARGMAX_DONE);
    assign accept        = bus.Argmax_InValid && in_ready;
    assign at_last_count = (count_q == LAST_COUNT);
    assign final_beat    = at_last_count || bus.Argmax_InLast;

    // A beat arriving together with Abort is discarded.
    assign cmp_load   = accept && !bus.Argmax_Abort && (count_q == '0);
    assign cmp_update = accept && !bus.Argmax_Abort && (count_q != '0);

    always_ff @(posedge Argmax_Clock or negedge Argmax_Reset_n) begin
        if (!Argmax_Reset_n) begin
            state_q <= ARGMAX_IDLE;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        error_d = error_q;
        unique case (state_q)
            ARGMAX_IDLE: begin
                if (bus.Argmax_Start && !bus.Argmax_Abort) begin
                    state_d = ARGMAX_COLLECT;
                    count_d = '0;
                    error_d = 1'b0;
                end
            end
            ARGMAX_COLLECT: begin
                if (bus.Argmax_Abort) begin
                    state_d = ARGMAX_IDLE;
                end else if (accept) begin
                    if (final_beat) begin
                        state_d = ARGMAX_DONE;
                        // Well-formed only when InLast coincides with the
                        // last counted beat: early InLast is a short frame,
                        // a full count without InLast is a missing last.
                        if (bus.Argmax_InLast != at_last_count) begin
                            error_d = 1'b1;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ARGMAX_DONE: begin
                // Start is never honoured here, even alongside the handshake.
                if (bus.Argmax_Abort || bus.Argmax_OutReady) begin
                    state_d = ARGMAX_IDLE;
                end
            end
            default: begin
                state_d = ARGMAX_IDLE;
            end
        endcase
    end

    argmax_compare_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_compare (
        .clk       (Argmax_Clock),
        .rst_n     (Argmax_Reset_n),
        .load      (cmp_load),
        .update    (cmp_update),
        .in_data   (bus.Argmax_InData),
        .in_idx    (count_q),
        .max_score (bus.Argmax_OutScore),
        .max_idx   (bus.Argmax_OutDigit)
    );

    assign bus.Argmax_InReady  = in_ready;
    assign bus.Argmax_OutValid = out_valid;
    assign bus.Argmax_Busy     = (state_q == ARGMAX_COLLECT) || (state_q == ARGMAX_DONE);
    assign bus.Argmax_Error    = error_q;
    assign bus.Argmax_DbgState = state_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
module tb_argmax_sequencer;
  import cnn4ic_pkg::*;

  localparam int W = 4 + 16 + 1;  // {digit, score, error}

  typedef logic [15:0] score_arr_t [10];

  logic clk;
  logic rst_n;
  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  argmax_sequencer_if #(.DATA_W(16), .IDX_W(4)) bus ();

  argmax_sequencer dut (
    .Argmax_Clock   (clk),
    .Argmax_Reset_n (rst_n),
    .bus            (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard: compares every accepted result against the queue
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && bus.Argmax_OutValid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_outvalid", 32'(bus.Argmax_OutValid), 32'd0);
      end else if (bus.Argmax_OutReady) begin
        e = exp_q.pop_front();
        chk("out_digit", 32'(bus.Argmax_OutDigit), 32'(e[20:17]));
        chk("out_score", 32'(bus.Argmax_OutScore), 32'(e[16:1]));
        chk("out_error", 32'(bus.Argmax_Error), 32'(e[0]));
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    while (bus.Argmax_DbgState != ARGMAX_IDLE && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic start_pulse();
    wait_idle();
    @(posedge clk); #1;
    bus.Argmax_Start = 1'b1;
    @(posedge clk); #1;
    bus.Argmax_Start = 1'b0;
  endtask

  // last_at < 0 means InLast never asserted; toggle inserts an invalid
  // cycle (with decoy data/InLast) before every beat after the first.
  task automatic send_frame(input score_arr_t sc, input int n, input int last_at,
                            input bit toggle, input bit chk_lat);
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) begin
        bus.Argmax_InValid = 1'b0;
        bus.Argmax_InData  = 16'h7FFE;
        bus.Argmax_InLast  = 1'b1;
        @(posedge clk); #1;
      end
      bus.Argmax_InValid = 1'b1;
      bus.Argmax_InData  = sc[i];
      bus.Argmax_InLast  = (i == last_at);
      if (chk_lat && i == n - 1) chk("outvalid_before_last", 32'(bus.Argmax_OutValid), 32'd0);
      @(posedge clk); #1;
    end
    bus.Argmax_InValid = 1'b0;
    bus.Argmax_InLast  = 1'b0;
    if (chk_lat) chk("outvalid_latency", 32'(bus.Argmax_OutValid), 32'd1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_inready"},  32'(bus.Argmax_InReady),  32'd0);
    chk({tag, "_outvalid"}, 32'(bus.Argmax_OutValid), 32'd0);
    chk({tag, "_digit"},    32'(bus.Argmax_OutDigit), 32'd0);
    chk({tag, "_score"},    32'(bus.Argmax_OutScore), 32'd0);
    chk({tag, "_busy"},     32'(bus.Argmax_Busy),     32'd0);
    chk({tag, "_error"},    32'(bus.Argmax_Error),    32'd0);
    chk({tag, "_state"},    32'(bus.Argmax_DbgState), 32'(ARGMAX_IDLE));
  endtask

  initial begin
    score_arr_t sc;
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.Argmax_Start    = 1'b0;
    bus.Argmax_Abort    = 1'b0;
    bus.Argmax_InData   = '0;
    bus.Argmax_InValid  = 1'b0;
    bus.Argmax_InLast   = 1'b0;
    bus.Argmax_OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic frame, max 9 at index 5, latency check
    sc = '{16'd3, -16'd2, 16'd7, 16'd1, 16'd0, 16'd9, 16'd4, -16'd8, 16'd2, 16'd5};
    start_pulse();
    chk("busy_collect", 32'(bus.Argmax_Busy), 32'd1);
    chk("inready_collect", 32'(bus.Argmax_InReady), 32'd1);
    exp_q.push_back({4'd5, 16'd9, 1'b0});
    send_frame(sc, 10, 9, 1'b0, 1'b1);
    wait_idle();

    // 2: tie between idx2 and idx7 keeps the lower index
    for (int i = 0; i < 10; i++) sc[i] = 16'hFF9C;  // -100
    sc[2] = 16'hFFFD;
    sc[7] = 16'hFFFD;
    start_pulse();
    exp_q.push_back({4'd2, 16'hFFFD, 1'b0});
    send_frame(sc, 10, 9, 1'b0, 1'b0);
    wait_idle();

    // 3: extreme values, InValid gapped with decoy data
    for (int i = 0; i < 10; i++) sc[i] = 16'h8000;
    sc[4] = 16'h7FFF;
    start_pulse();
    exp_q.push_back({4'd4, 16'h7FFF, 1'b0});
    send_frame(sc, 10, 9, 1'b1, 1'b0);
    wait_idle();

    // 4: short frame, InLast on beat 5
    sc = '{16'd1, 16'd2, 16'd3, 16'd10, -16'd5, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0};
    start_pulse();
    exp_q.push_back({4'd3, 16'd10, 1'b1});
    send_frame(sc, 6, 5, 1'b0, 1'b0);
    wait_idle();
    chk("error_sticky_idle", 32'(bus.Argmax_Error), 32'd1);
    start_pulse();
    chk("error_cleared_on_start", 32'(bus.Argmax_Error), 32'd0);

    // 5: missing InLast, result held under back-pressure, Start ignored
    sc = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, -16'd1, -16'd2, -16'd3, 16'd20};
    bus.Argmax_OutReady = 1'b0;
    exp_q.push_back({4'd9, 16'd20, 1'b1});
    send_frame(sc, 10, -1, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      bus.Argmax_Start   = (i == 5);
      bus.Argmax_InValid = 1'b1;
      bus.Argmax_InData  = 16'h7FFF;
      if (bus.Argmax_OutValid !== 1'b1 || bus.Argmax_OutDigit !== 4'd9 ||
          bus.Argmax_OutScore !== 16'd20 || bus.Argmax_InReady !== 1'b0 ||
          bus.Argmax_DbgState !== ARGMAX_DONE) n++;
      @(posedge clk); #1;
    end
    chk("hold_unstable_cycles", 32'(n), 32'd0);
    chk("hold_error", 32'(bus.Argmax_Error), 32'd1);
    bus.Argmax_InValid  = 1'b0;
    bus.Argmax_Start    = 1'b1;  // coincides with the handshake, must be dropped
    bus.Argmax_OutReady = 1'b1;
    @(posedge clk); #1;
    bus.Argmax_Start = 1'b0;
    chk("release_state", 32'(bus.Argmax_DbgState), 32'(ARGMAX_IDLE));
    chk("release_busy", 32'(bus.Argmax_Busy), 32'd0);
    @(posedge clk); #1;
    chk("start_dropped_state", 32'(bus.Argmax_DbgState), 32'(ARGMAX_IDLE));

    // 6: abort after beat 4, then reset mid-frame
    sc = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 16'd66, 16'd0, 16'd0, 16'd0, 16'd0};
    start_pulse();
    send_frame(sc, 5, -1, 1'b0, 1'b0);
    bus.Argmax_Abort = 1'b1;
    @(posedge clk); #1;
    bus.Argmax_Abort = 1'b0;
    chk("abort_state", 32'(bus.Argmax_DbgState), 32'(ARGMAX_IDLE));
    chk("abort_outvalid", 32'(bus.Argmax_OutValid), 32'd0);
    chk("abort_busy", 32'(bus.Argmax_Busy), 32'd0);
    chk("abort_inready", 32'(bus.Argmax_InReady), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    start_pulse();
    send_frame(sc, 3, -1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_values("postreset");
    repeat (5) @(posedge clk);
    #1;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
